// File: rtl/imu_pkg.sv
// rtl/imu_pkg.sv - shared types and helpers for the IMU sample packer
// Purpose: FSM state enum, float32 type, float bias and a 24-bit
//          leading-zero counter used by the int-to-float converter.
// Ports:   none (package).
package imu_pkg;

  localparam int FLOAT_BIAS = 127;
  localparam int SAMPLE_W   = 16;
  localparam int CONV_W     = 24;

  typedef logic [31:0] float32_t;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_A,
    ISSUE_R,
    ISSUE_D,
    DRAIN,
    PUBLISH
  } state_e;

  // Number of zeros above the most significant set bit; 24 means x == 0.
  function automatic logic [4:0] lzc24(input logic [CONV_W-1:0] x);
    logic [4:0] n;
    logic       found;
    n     = 5'd24;
    found = 1'b0;
    for (int i = CONV_W - 1; i >= 0; i--) begin
      if (!found && x[i]) begin
        n     = 5'(CONV_W - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/int2float_seq.sv
// rtl/int2float_seq.sv - two-stage 24-bit integer to float32 converter
// Purpose: converts a 24-bit integer (two's complement, or unsigned when
//          in_unsigned_i is set) to float32 scaled by 2^-adj_i.
//          Latency 2 cycles, one new input accepted every cycle.
// Ports:   clk, reset     clock, synchronous active-high reset
//          in_data_i      24-bit integer input
//          in_valid_i     input qualifier
//          in_unsigned_i  treat in_data_i as unsigned (sign forced 0)
//          adj_i          power-of-two exponent reduction, 0..100
//          out_data_o     float32 result
//          out_valid_o    result qualifier, two cycles after in_valid_i
module int2float_seq
  import imu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [CONV_W-1:0] in_data_i,
  input  logic              in_valid_i,
  input  logic              in_unsigned_i,
  input  logic [6:0]        adj_i,
  output float32_t          out_data_o,
  output logic              out_valid_o
);

  logic              s1_valid_q, s1_sign_q;
  logic [CONV_W-1:0] s1_mag_q;
  logic [4:0]        s1_lzc_q;
  logic [6:0]        s1_adj_q;
  logic              out_valid_q;
  float32_t          out_data_q;

  logic              sign_d;
  logic [CONV_W-1:0] mag_d;
  logic [4:0]        lzc_d;
  logic [CONV_W-1:0] norm;
  logic [8:0]        exp9;
  float32_t          packed_d;

  // Stage 1: sign, magnitude, leading-zero count.
  always_comb begin
    sign_d = in_data_i[CONV_W-1] & ~in_unsigned_i;
    mag_d  = sign_d ? (~in_data_i + 24'd1) : in_data_i;
    lzc_d  = lzc24(mag_d);
  end

  // Stage 2: shift the leading one to bit 23 (it becomes the hidden bit).
  // Inputs never exceed 24 significant bits, so no rounding is needed.
  always_comb begin
    norm     = s1_mag_q << s1_lzc_q;
    exp9     = 9'(FLOAT_BIAS + CONV_W - 1) - {4'b0, s1_lzc_q} - {2'b0, s1_adj_q};
    packed_d = (s1_lzc_q == 5'd24) ? 32'h0 : {s1_sign_q, exp9[7:0], norm[22:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s1_lzc_q    <= '0;
      s1_adj_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= in_valid_i;
      s1_sign_q   <= sign_d;
      s1_mag_q    <= mag_d;
      s1_lzc_q    <= lzc_d;
      s1_adj_q    <= adj_i;
      out_valid_q <= s1_valid_q;
      out_data_q  <= packed_d;
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;

endmodule

// File: rtl/imu_sample_packer.sv
// rtl/imu_sample_packer.sv - IMU sample to float32 packer for the Kalman stage
// Purpose: accepts signed 16-bit accel/rate samples, measures the tick
//          interval since the previous sample and publishes all three as
//          scaled float32 values with a one-cycle strobe, one sample per 7 clk.
// Ports:   clk, reset          clock, synchronous active-high reset
//          sample_valid/ready  upstream handshake
//          sample_accel/rate   signed 16-bit samples
//          new_data_available  one-cycle strobe, outputs valid
//          new_accel/new_rate  float32, sample * 2^-ADJ
//          dt                  float32, ticks * 2^-DT_EXP
module imu_sample_packer
  import imu_pkg::*;
#(
  parameter int TICK_DIV      = 48,
  parameter int DT_EXP        = 20,
  parameter int ACCEL_EXP_ADJ = 14,
  parameter int RATE_EXP_ADJ  = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample_accel,
  input  logic [SAMPLE_W-1:0] sample_rate,
  output logic                new_data_available,
  output float32_t            new_accel,
  output float32_t            new_rate,
  output float32_t            dt
);

  localparam int         PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [6:0] ADJ_A = 7'(ACCEL_EXP_ADJ);
  localparam logic [6:0] ADJ_R = 7'(RATE_EXP_ADJ);
  localparam logic [6:0] ADJ_D = 7'(DT_EXP);

  state_e              state_q, state_d;
  logic                drain_q, drain_d;
  logic [PRE_W-1:0]    pre_q;
  logic [CONV_W-1:0]   tick_q;
  logic                first_q;
  logic [SAMPLE_W-1:0] accel_q, rate_q;
  logic [CONV_W-1:0]   delta_q;
  float32_t            acc_hold_q, rate_hold_q, dt_hold_q;
  float32_t            new_accel_q, new_rate_q, dt_q;
  logic                nda_q;

  logic                accept, wrap, publish;
  logic                cv_valid, cv_unsigned, cv_out_valid;
  logic [CONV_W-1:0]   cv_data;
  logic [6:0]          cv_adj;
  float32_t            cv_out;

  assign sample_ready = (state_q == IDLE) && !reset;
  assign accept       = sample_valid && sample_ready;
  assign wrap         = (pre_q == PRE_W'(TICK_DIV - 1));

  // One converter slot per ISSUE state; results come back two cycles later
  // in ISSUE_D (accel) and the two DRAIN cycles (rate, then dt).
  always_comb begin
    state_d     = state_q;
    drain_d     = 1'b0;
    cv_valid    = 1'b0;
    cv_unsigned = 1'b0;
    cv_data     = '0;
    cv_adj      = '0;
    publish     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) state_d = ISSUE_A;
      end
      ISSUE_A: begin
        cv_valid = 1'b1;
        cv_data  = {{(CONV_W - SAMPLE_W){accel_q[SAMPLE_W-1]}}, accel_q};
        cv_adj   = ADJ_A;
        state_d  = ISSUE_R;
      end
      ISSUE_R: begin
        cv_valid = 1'b1;
        cv_data  = {{(CONV_W - SAMPLE_W){rate_q[SAMPLE_W-1]}}, rate_q};
        cv_adj   = ADJ_R;
        state_d  = ISSUE_D;
      end
      ISSUE_D: begin
        cv_valid    = 1'b1;
        cv_data     = delta_q;
        cv_unsigned = 1'b1;
        cv_adj      = ADJ_D;
        state_d     = DRAIN;
      end
      DRAIN: begin
        drain_d = ~drain_q;
        if (drain_q) state_d = PUBLISH;
      end
      PUBLISH: begin
        publish = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  int2float_seq u_conv (
    .clk          (clk),
    .reset        (reset),
    .in_data_i    (cv_data),
    .in_valid_i   (cv_valid),
    .in_unsigned_i(cv_unsigned),
    .adj_i        (cv_adj),
    .out_data_o   (cv_out),
    .out_valid_o  (cv_out_valid)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      drain_q     <= 1'b0;
      pre_q       <= '0;
      tick_q      <= '0;
      first_q     <= 1'b1;
      accel_q     <= '0;
      rate_q      <= '0;
      delta_q     <= '0;
      acc_hold_q  <= '0;
      rate_hold_q <= '0;
      dt_hold_q   <= '0;
      new_accel_q <= '0;
      new_rate_q  <= '0;
      dt_q        <= '0;
      nda_q       <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      pre_q   <= wrap ? '0 : pre_q + 1'b1;

      // Accept clears the counter even if a tick lands on the same edge.
      if (accept) begin
        tick_q  <= '0;
        first_q <= 1'b0;
        accel_q <= sample_accel;
        rate_q  <= sample_rate;
        delta_q <= first_q ? '0 : tick_q;
      end else if (wrap && (tick_q != '1)) begin
        tick_q <= tick_q + 1'b1;
      end

      if (cv_out_valid) begin
        if (state_q == ISSUE_D) acc_hold_q <= cv_out;
        else if (state_q == DRAIN && !drain_q) rate_hold_q <= cv_out;
        else if (state_q == DRAIN) dt_hold_q <= cv_out;
      end

      nda_q <= publish;
      if (publish) begin
        new_accel_q <= acc_hold_q;
        new_rate_q  <= rate_hold_q;
        dt_q        <= dt_hold_q;
      end
    end
  end

  assign new_data_available = nda_q;
  assign new_accel          = new_accel_q;
  assign new_rate           = new_rate_q;
  assign dt                 = dt_q;

endmodule
